// File: rtl/de2_115_qsys_button_pio_pkg.sv
// Shared definitions for the button input PIO: register word addresses and edge-type encodings.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/de2_115_qsys_button_pio_if.sv
// Avalon-MM slave bus plus level interrupt for the button input PIO.
interface de2_115_qsys_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/de2_115_qsys_button_pio_debounce.sv
// One input bit: two-flop synchroniser followed by a counter that must see the new level
// for DEBOUNCE_CYCLES consecutive clocks before the debounced state follows it.
module pio_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IN_RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET_VAL;
            sync2 <= IN_RESET_VAL;
            state <= IN_RESET_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the accepted level restarts qualification from zero.
            if (sync2 == state) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                state <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/de2_115_qsys_button_pio.sv
// Avalon-MM input PIO for player buttons: debounced data, per-bit edge capture and a
// masked level interrupt to the Nios II.
module de2_115_qsys_button_pio
    import pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0,
    parameter bit IN_RESET_VAL    = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    de2_115_qsys_button_pio_if.slave   bus,
    input  logic [WIDTH-1:0]           in_port
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clear;
    logic [31:0]      rdata;
    logic             wr;
    logic             unused_writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .IN_RESET_VAL    (IN_RESET_VAL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (in_port[i]),
            .state   (state[i])
        );
    end

    assign wr               = bus.chipselect & ~bus.write_n;
    assign unused_writedata = ^bus.writedata;

    always_comb begin
        edges = '0;
        case (EDGE_TYPE)
            EDGE_RISE: edges = state & ~state_d;
            EDGE_FALL: edges = ~state & state_d;
            default:   edges = state ^ state_d;
        endcase
    end

    always_comb begin
        clear = '0;
        if (wr && bus.address == ADDR_EDGECAP)
            clear = bus.writedata[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_d      <= {WIDTH{IN_RESET_VAL}};
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            state_d <= state;
            if (wr && bus.address == ADDR_IRQMASK)
                irq_mask <= bus.writedata[WIDTH-1:0];
            // OR-ing new edges after the clear lets a same-cycle edge survive the W1C.
            edge_capture <= (edge_capture & ~clear) | edges;
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:    rdata[WIDTH-1:0] = state;
            ADDR_IRQMASK: rdata[WIDTH-1:0] = irq_mask;
            ADDR_EDGECAP: rdata[WIDTH-1:0] = edge_capture;
            default:      rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign bus.irq      = |(edge_capture & irq_mask);

endmodule
